// File: rtl/password_lock_n_pkg.sv
// Shared types and helpers for the N-digit keypad lock.
// Holds the controller state encoding and the hex-digit 7-segment decoder.
package password_lock_n_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY  = 3'd0,
        ST_CHECK  = 3'd1,
        ST_OPEN   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_PROG   = 3'd4
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Segments are active-high, ordered {g,f,e,d,c,b,a}; A-F use the usual hex glyphs.
    function automatic logic [SEG_W-1:0] seg7(input logic [DIGIT_W-1:0] v);
        logic [SEG_W-1:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/password_lock_n_press_edge.sv
// Rising-edge detector for the debounced enter button.
// One strobe per press no matter how long the button is held.
module press_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic strobe
);

    logic level_q;

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign strobe = level & ~level_q;

endmodule

// File: rtl/password_lock_n.sv
// N-digit keypad lock: compare-at-end entry, retry limit with timed lockout,
// auto-relocking open window and in-place code reprogramming.
module password_lock_n
    import password_lock_n_pkg::*;
#(
    parameter int                    N_DIGITS      = 4,
    parameter logic [N_DIGITS*4-1:0] DEFAULT_PWD   = 16'h1512,
    parameter int                    MAX_TRIES     = 3,
    parameter int                    LOCK_CYCLES   = 50000000,
    parameter int                    OPEN_CYCLES   = 250000000,
    parameter int                    ENTRY_TIMEOUT = 250000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enter,
    input  logic [3:0]            digit_in,
    input  logic                  clear,
    input  logic                  prog,
    output logic                  admitted,
    output logic                  locked_out,
    output logic                  fail,
    output logic [3:0]            tries_left,
    output logic [N_DIGITS:0]     status,
    output logic [7*N_DIGITS-1:0] disp,
    output logic [6:0]            din
);

    localparam int CW     = N_DIGITS * DIGIT_W;
    localparam int IW     = $clog2(N_DIGITS);
    localparam int MAX_LO = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
    localparam int MAX_T  = (MAX_LO > ENTRY_TIMEOUT) ? MAX_LO : ENTRY_TIMEOUT;
    localparam int TW     = (MAX_T > 2) ? $clog2(MAX_T) : 1;

    localparam logic [TW-1:0] LOAD_LOCK  = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOAD_OPEN  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOAD_ENTRY = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);
    localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);

    state_t                           state;
    logic   [IW-1:0]                  idx;
    logic   [N_DIGITS-1:0][DIGIT_W-1:0] entry;
    logic   [N_DIGITS-1:0][DIGIT_W-1:0] shadow;
    logic   [N_DIGITS-1:0][DIGIT_W-1:0] shadow_next;
    logic   [N_DIGITS-1:0][DIGIT_W-1:0] shown;
    logic   [CW-1:0]                  code;
    logic   [TW-1:0]                  timer;
    logic   [3:0]                     tries_q;
    logic                             fail_q;
    logic                             strobe;

    press_edge u_press_edge (
        .clk    (clk),
        .rst    (rst),
        .level  (enter),
        .strobe (strobe)
    );

    // Entered digit 0 is the first one typed, which lives in the MSBs of a code word.
    function automatic logic [CW-1:0] to_word(input logic [N_DIGITS-1:0][DIGIT_W-1:0] d);
        logic [CW-1:0] w;
        w = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = d[i];
        end
        return w;
    endfunction

    // NOTE: every always_comb output gets a full default first so no latch can be inferred.
    always_comb begin
        shadow_next      = shadow;
        shadow_next[idx] = digit_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_ENTRY;
            idx     <= '0;
            entry   <= '0;
            shadow  <= '0;
            code    <= DEFAULT_PWD;
            tries_q <= TRIES_INIT;
            timer   <= '0;
            fail_q  <= 1'b0;
        end else begin
            fail_q <= 1'b0;
            case (state)
                ST_ENTRY: begin
                    // Abort and idle expiry both win over a strobe arriving in the same cycle.
                    if (clear || (timer == '0 && idx != '0)) begin
                        idx   <= '0;
                        entry <= '0;
                        timer <= LOAD_ENTRY;
                    end else if (strobe) begin
                        entry[idx] <= digit_in;
                        timer      <= LOAD_ENTRY;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= ST_CHECK;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (timer == '0) begin
                        timer <= LOAD_ENTRY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_CHECK: begin
                    if (to_word(entry) == code) begin
                        state   <= ST_OPEN;
                        tries_q <= TRIES_INIT;
                        timer   <= LOAD_OPEN;
                    end else begin
                        fail_q <= 1'b1;
                        entry  <= '0;
                        if (tries_q <= 4'd1) begin
                            tries_q <= 4'd0;
                            state   <= ST_LOCKED;
                            timer   <= LOAD_LOCK;
                        end else begin
                            tries_q <= tries_q - 4'd1;
                            state   <= ST_ENTRY;
                            timer   <= LOAD_ENTRY;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (timer == '0) begin
                        state   <= ST_ENTRY;
                        tries_q <= TRIES_INIT;
                        timer   <= LOAD_ENTRY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_OPEN: begin
                    if (clear || timer == '0) begin
                        state <= ST_ENTRY;
                        idx   <= '0;
                        entry <= '0;
                        timer <= LOAD_ENTRY;
                    end else if (prog) begin
                        // Timer is left untouched: the open window does not run while programming.
                        state  <= ST_PROG;
                        idx    <= '0;
                        shadow <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_PROG: begin
                    if (clear) begin
                        state <= ST_ENTRY;
                        idx   <= '0;
                        entry <= '0;
                        timer <= LOAD_ENTRY;
                    end else if (strobe) begin
                        shadow <= shadow_next;
                        if (idx == LAST_IDX) begin
                            code  <= to_word(shadow_next);
                            state <= ST_ENTRY;
                            idx   <= '0;
                            entry <= '0;
                            timer <= LOAD_ENTRY;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_ENTRY;
                    idx   <= '0;
                    entry <= '0;
                    timer <= LOAD_ENTRY;
                end
            endcase
        end
    end

    assign admitted   = (state == ST_OPEN);
    assign locked_out = (state == ST_LOCKED);
    assign fail       = fail_q;
    assign tries_left = tries_q;

    always_comb begin
        status = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            status[i] = (state == ST_ENTRY || state == ST_PROG) && (idx == IW'(i));
        end
        status[N_DIGITS] = (state == ST_OPEN);
    end

    // While programming, the displays follow the new code being typed.
    assign shown = (state == ST_PROG) ? shadow : entry;

    for (genvar g = 0; g <= N_DIGITS; g++) begin : g_seg
        if (g < N_DIGITS) begin : g_disp
            assign disp[g*SEG_W +: SEG_W] = seg7(shown[g]);
        end else begin : g_din
            assign din = seg7(digit_in);
        end
    end

endmodule
